// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath widths, PC step, memory access sizes
// and the fetch-buffer entry layout.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    // Access size encoding shared by the memory and the data-side port
    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } mem_size_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] opcode;
    } fetch_entry_t;

    localparam int unsigned FETCH_ENTRY_W = XLEN + ILEN;

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Opcode buffer for the fetch unit: {pc, opcode} entries with a synchronous
// flush; the head is zero whenever the buffer is empty.
module riscv_fetch_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      flush_i,
    input  logic                      push_i,
    input  fetch_entry_t              push_data_i,
    input  logic                      pop_i,
    output fetch_entry_t              head_o,
    output logic [$clog2(DEPTH):0]    count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t    mem_q [DEPTH];
    logic [AW-1:0]   wr_q;
    logic [AW-1:0]   rd_q;
    logic [CW-1:0]   count_q;

    logic push_ok;
    logic pop_ok;

    assign push_ok = push_i & ~flush_i & ~reset_i;
    assign pop_ok  = pop_i & ~flush_i & ~reset_i;

    // Pointer and occupancy state; flush empties the buffer in one cycle
    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                wr_q <= wr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_q <= rd_q + AW'(1);
            end
            count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_q] <= push_data_i;
        end
    end

    assign head_o  = (count_q != '0) ? mem_q[rd_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/riscv_fetch.sv
// Instruction fetch: PC sequencing, credit-limited read issue to the
// instruction memory port, response capture and decoder handshake.
module riscv_fetch
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned     MEM_LAT  = 1,
    parameter int unsigned     DEPTH    = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              fetch_en_i,
    input  logic              redirect_i,
    input  logic [XLEN-1:0]   redirect_pc_i,
    output logic [XLEN-1:0]   iaddr_o,
    output logic              ird_o,
    input  logic [ILEN-1:0]   irdata_i,
    output logic              fetch_valid_o,
    input  logic              fetch_ready_i,
    output logic [ILEN-1:0]   fetch_opcode_o,
    output logic [XLEN-1:0]   fetch_pc_o
);

    localparam int unsigned     CW         = $clog2(DEPTH) + 1;
    localparam int unsigned     SW         = $clog2(DEPTH + MEM_LAT) + 1;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic [XLEN-1:0]    pc_q;
    logic [MEM_LAT-1:0] infl_q;
    logic [XLEN-1:0]    infl_pc_q [MEM_LAT];

    logic [CW-1:0]      fifo_count;
    fetch_entry_t       head;
    fetch_entry_t       push_data;
    logic [SW-1:0]      infl_cnt;
    logic [SW-1:0]      credit_used;
    logic               valid_c;
    logic               pop;
    logic               push;
    logic               issue;

    always_comb begin
        infl_cnt = '0;
        for (int i = 0; i < int'(MEM_LAT); i++) begin
            infl_cnt = infl_cnt + SW'(infl_q[i]);
        end
    end

    // Redirect hides the head so nothing is consumed in the flush cycle
    assign valid_c     = (fifo_count != '0) & ~redirect_i;
    assign pop         = valid_c & fetch_ready_i;
    assign credit_used = infl_cnt + SW'(fifo_count) - SW'(pop);
    assign issue       = fetch_en_i & ~redirect_i & ~reset_i & (credit_used < SW'(DEPTH));
    assign push        = infl_q[MEM_LAT-1] & ~redirect_i & ~reset_i;

    assign push_data.pc     = infl_pc_q[MEM_LAT-1];
    assign push_data.opcode = irdata_i;

    // PC and in-flight tracking; reset and redirect drop every outstanding read
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_q   <= RESET_PC;
            infl_q <= '0;
        end else if (redirect_i) begin
            pc_q   <= redirect_pc_i & ALIGN_MASK;
            infl_q <= '0;
        end else begin
            if (issue) begin
                pc_q <= pc_q + PC_STEP;
            end
            for (int i = int'(MEM_LAT) - 1; i > 0; i--) begin
                infl_q[i] <= infl_q[i-1];
            end
            infl_q[0] <= issue;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = int'(MEM_LAT) - 1; i > 0; i--) begin
            infl_pc_q[i] <= infl_pc_q[i-1];
        end
        infl_pc_q[0] <= pc_q;
    end

    riscv_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .flush_i     (redirect_i),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (fifo_count)
    );

    assign iaddr_o        = pc_q;
    assign ird_o          = issue;
    assign fetch_valid_o  = valid_c;
    assign fetch_opcode_o = head.opcode;
    assign fetch_pc_o     = head.pc;

endmodule

// File: tb/tb_riscv_fetch.sv
// Bench for riscv_fetch: directed vector table for the fetch scenarios, then a
// randomized run checked against an issue/scoreboard model.
module tb_riscv_fetch;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        fetch_en_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] iaddr_o;
    logic        ird_o;
    logic [31:0] irdata_i;
    logic        fetch_valid_o;
    logic        fetch_ready_i;
    logic [31:0] fetch_opcode_o;
    logic [31:0] fetch_pc_o;

    always #5 clk = ~clk;

    riscv_fetch #(
        .RESET_PC (32'h0000_0000),
        .MEM_LAT  (1),
        .DEPTH    (DEPTH)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .fetch_en_i     (fetch_en_i),
        .redirect_i     (redirect_i),
        .redirect_pc_i  (redirect_pc_i),
        .iaddr_o        (iaddr_o),
        .ird_o          (ird_o),
        .irdata_i       (irdata_i),
        .fetch_valid_o  (fetch_valid_o),
        .fetch_ready_i  (fetch_ready_i),
        .fetch_opcode_o (fetch_opcode_o),
        .fetch_pc_o     (fetch_pc_o)
    );

    typedef struct {
        logic        rst, en, rdy, redir;
        logic [31:0] rpc;
        logic        full;
        logic        e_ird;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_pc;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        int          cyc;
    } sb_t;

    vec_t        tbl[$];
    sb_t         sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          now   = 0;
    logic        mem_req  = 1'b0;
    logic [31:0] mem_addr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h0010_8113;
        return a ^ 32'h5A5A_0013;
    endfunction

    function automatic vec_t v(input logic rst, en, rdy, redir, input logic [31:0] rpc,
                               input logic full, e_ird, input logic [31:0] e_addr,
                               input logic e_vld, input logic [31:0] e_pc);
        vec_t r;
        r.rst = rst; r.en = en; r.rdy = rdy; r.redir = redir; r.rpc = rpc;
        r.full = full; r.e_ird = e_ird; r.e_addr = e_addr; r.e_vld = e_vld; r.e_pc = e_pc;
        return r;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, want %08h", name, act, exp);
        end
    endtask

    // One clock: drive inputs and the memory response 1ns after the edge, sample at 2ns
    task automatic step(input logic rst, en, rdy, redir, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        irdata_i      = mem_req ? mem_word(mem_addr) : $urandom();
        reset_i       = rst;
        fetch_en_i    = en;
        fetch_ready_i = rdy;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        #1;
        mem_req  = ird_o;
        mem_addr = iaddr_o;
        now++;
    endtask

    task automatic add_stall_prefix();
        tbl.push_back(v(1,1,0,0,0,          0,0,0,      0,0));
        tbl.push_back(v(0,1,0,0,0,          1,1,32'h0,  0,0));
        tbl.push_back(v(0,1,0,0,0,          1,1,32'h4,  0,0));
        tbl.push_back(v(0,1,0,0,0,          1,1,32'h8,  1,32'h0));
    endtask

    initial begin
        logic        en, rdy, redir, exp_vld, exp_ird;
        logic [31:0] rpc, ref_pc;

        reset_i = 1'b1; fetch_en_i = 1'b0; fetch_ready_i = 1'b0;
        redirect_i = 1'b0; redirect_pc_i = '0; irdata_i = '0;

        // Reset and streaming start
        tbl.push_back(v(1,1,1,0,0,          0,0,0,      0,0));
        tbl.push_back(v(1,1,1,0,0,          1,0,32'h0,  0,0));
        tbl.push_back(v(0,1,1,0,0,          1,1,32'h0,  0,0));
        tbl.push_back(v(0,1,1,0,0,          1,1,32'h4,  0,0));
        tbl.push_back(v(0,1,1,0,0,          1,1,32'h8,  1,32'h0));
        tbl.push_back(v(0,1,1,0,0,          1,1,32'hC,  1,32'h4));
        tbl.push_back(v(0,1,1,0,0,          1,1,32'h10, 1,32'h8));
        // Decoder stall: buffer fills to DEPTH then issue stops
        add_stall_prefix();
        tbl.push_back(v(0,1,0,0,0,          1,1,32'hC,  1,32'h0));
        for (int i = 0; i < 6; i++)
            tbl.push_back(v(0,1,0,0,0,      1,0,32'h10, 1,32'h0));
        tbl.push_back(v(0,1,1,0,0,          1,1,32'h10, 1,32'h0));
        tbl.push_back(v(0,1,1,0,0,          1,1,32'h14, 1,32'h4));
        tbl.push_back(v(0,1,1,0,0,          1,1,32'h18, 1,32'h8));
        tbl.push_back(v(0,1,1,0,0,          1,1,32'h1C, 1,32'hC));
        tbl.push_back(v(0,1,1,0,0,          1,1,32'h20, 1,32'h10));
        // Redirect with entries buffered and a read landing
        add_stall_prefix();
        tbl.push_back(v(0,1,0,1,32'h100,    1,0,32'hC,  0,0));
        tbl.push_back(v(0,1,1,0,0,          1,1,32'h100,0,0));
        tbl.push_back(v(0,1,1,0,0,          1,1,32'h104,0,0));
        tbl.push_back(v(0,1,1,0,0,          1,1,32'h108,1,32'h100));
        // Misaligned redirect target
        tbl.push_back(v(0,1,1,1,32'h203,    1,0,32'h10C,0,0));
        tbl.push_back(v(0,1,1,0,0,          1,1,32'h200,0,0));
        tbl.push_back(v(0,1,1,0,0,          1,1,32'h204,0,0));
        tbl.push_back(v(0,1,1,0,0,          1,1,32'h208,1,32'h200));
        // Fetch enable dropped for three cycles
        tbl.push_back(v(0,0,1,0,0,          1,0,32'h20C,1,32'h204));
        tbl.push_back(v(0,0,1,0,0,          1,0,32'h20C,1,32'h208));
        tbl.push_back(v(0,0,1,0,0,          1,0,32'h20C,0,0));
        tbl.push_back(v(0,1,1,0,0,          1,1,32'h20C,0,0));
        tbl.push_back(v(0,1,1,0,0,          1,1,32'h210,0,0));
        tbl.push_back(v(0,1,1,0,0,          1,1,32'h214,1,32'h20C));
        // Reset one cycle after an issue
        tbl.push_back(v(1,1,1,0,0,          0,0,0,      0,0));
        tbl.push_back(v(0,0,1,0,0,          1,0,32'h0,  0,0));
        tbl.push_back(v(0,0,1,0,0,          1,0,32'h0,  0,0));
        tbl.push_back(v(0,1,1,0,0,          1,1,32'h0,  0,0));
        tbl.push_back(v(0,1,1,0,0,          1,1,32'h4,  0,0));
        tbl.push_back(v(0,1,1,0,0,          1,1,32'h8,  1,32'h0));
        // PC wrap at the top of the address space
        tbl.push_back(v(0,1,1,1,32'hFFFF_FFFB, 1,0,32'hC, 0,0));
        tbl.push_back(v(0,1,1,0,0,          1,1,32'hFFFF_FFF8,0,0));
        tbl.push_back(v(0,1,1,0,0,          1,1,32'hFFFF_FFFC,0,0));
        tbl.push_back(v(0,1,1,0,0,          1,1,32'h0,  1,32'hFFFF_FFF8));
        tbl.push_back(v(0,1,1,0,0,          1,1,32'h4,  1,32'hFFFF_FFFC));
        tbl.push_back(v(0,1,1,0,0,          1,1,32'h8,  1,32'h0));

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].rdy, tbl[i].redir, tbl[i].rpc);
            check32($sformatf("v%0d ird", i), 32'(ird_o), 32'(tbl[i].e_ird));
            if (tbl[i].full) begin
                check32($sformatf("v%0d iaddr", i), iaddr_o, tbl[i].e_addr);
                check32($sformatf("v%0d valid", i), 32'(fetch_valid_o), 32'(tbl[i].e_vld));
                if (tbl[i].e_vld) begin
                    check32($sformatf("v%0d pc", i), fetch_pc_o, tbl[i].e_pc);
                    check32($sformatf("v%0d opcode", i), fetch_opcode_o, mem_word(tbl[i].e_pc));
                end else if (!tbl[i].redir) begin
                    check32($sformatf("v%0d pc_idle", i), fetch_pc_o, 32'h0);
                    check32($sformatf("v%0d opcode_idle", i), fetch_opcode_o, 32'h0);
                end
            end
        end

        // Randomized traffic against the scoreboard, then a drain
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        ref_pc = 32'h0;
        sb.delete();
        for (int k = 0; k < 420; k++) begin
            en    = ($urandom_range(0, 9) != 0);
            rdy   = ($urandom_range(0, 9) < 7);
            redir = ($urandom_range(0, 24) == 0);
            rpc   = $urandom();
            if (k >= 400) begin
                en = 1'b0; rdy = 1'b1; redir = 1'b0;
            end
            step(1'b0, en, rdy, redir, rpc);

            exp_vld = !redir && (sb.size() > 0) && (sb[0].cyc + 2 <= now);
            check32($sformatf("r%0d valid", k), 32'(fetch_valid_o), 32'(exp_vld));
            if (exp_vld) begin
                check32($sformatf("r%0d pc", k), fetch_pc_o, sb[0].pc);
                check32($sformatf("r%0d opcode", k), fetch_opcode_o, mem_word(sb[0].pc));
                if (rdy) void'(sb.pop_front());
            end
            exp_ird = !redir && en && (sb.size() < DEPTH);
            check32($sformatf("r%0d ird", k), 32'(ird_o), 32'(exp_ird));
            check32($sformatf("r%0d iaddr", k), iaddr_o, ref_pc);
            if (redir) begin
                sb.delete();
                ref_pc = rpc & 32'hFFFF_FFFC;
            end else if (exp_ird) begin
                sb.push_back('{pc: ref_pc, cyc: now});
                ref_pc = ref_pc + 32'd4;
            end
        end
        check32("drain_empty", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
